thermo_count: RTL and testbench
===============================

# thermo_count

Pipelined, elastic thermometer-to-binary encoder that converts prefix-AND propagate masks back into a binary trailing-ones count. It is the consumer-side counterpart of the propagate prefix structures: each input word is a mask with bits 0..k-1 set, and the block returns k. It is used in incrementer, normalisation and leading-digit datapaths wherever a group-propagate mask must become a shift or position value. It has valid/ready handshakes on both sides, a two-stage pipeline, and optional bubble (malformed code) detection.

## Interface
- width, 8: input mask width; must be ≥ 2.
- cw, $clog2(width+1): count width (derived localparam, not overridable).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- valid_i  in  1  input word valid.
- ready_o  out  1  block accepts a word this cycle.
- TI  in  width  thermometer mask; bit 0 is the LSB group.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts a result.
- CNT  out  cw  trailing-ones count of the accepted mask, 0..width.
- ERR  out  1  the mask was not a legal thermometer code.
- ERRCNT  out  16  saturating count of results delivered with ERR=1.
- errclr_i  in  1  synchronous clear of ERRCNT.

## Operation
- Legal code: TI = 2^k − 1 for k in 0..width. CNT = k.
- CNT is always the count of contiguous ones starting at bit 0, which is the index of the lowest 0 bit, or width if all bits are 1. This holds for illegal masks too: 0b1011 gives CNT=2.
- ERR=1 iff any bit at or above index CNT is 1. Equivalently, TI ≠ 2^CNT − 1.
- Stage 1 (S1) registers TI when a word is accepted.
- Stage 2 (S2) registers the encoded CNT and ERR, computed combinationally from the S1 register. This is a log-depth priority encode over the inverted mask. The CNT computation and the ERR computation have independent logic paths.
- Each stage has a valid bit. A stage advances when it is empty or when its downstream slot frees in the same cycle:
  - S2 frees when valid_o && ready_i.
  - S2 loads when S1 is valid and S2 is empty or freeing.
  - ready_o = !s1_valid || (s2 frees or s2 empty).
  - ready_o therefore depends combinationally on ready_i. This path is intended.
- Accept: valid_i && ready_o. Deliver: valid_o && ready_i.
- Handshake rules:
  - valid_o, CNT and ERR are held stable while valid_o && !ready_i.
  - No result is dropped or duplicated.
  - A word is not accepted while ready_o=0.
- ERRCNT:
  - Increments by 1 on each delivery with ERR=1.
  - Saturates at 16'hFFFF.
  - errclr_i forces ERRCNT to 0. If a clear and an error delivery occur in the same cycle, the clear wins and ERRCNT becomes 0.

## Timing
- Latency: a word accepted at edge n appears on valid_o/CNT/ERR after edge n+1. That is two register stages with no bypass.
- Throughput: one word per cycle with ready_i held at 1.
- Full condition: with ready_i=0, two words fill S1 and S2, after which ready_o=0. The first cycle with ready_i=1 both delivers a result and accepts a new word.
- Empty condition: valid_o=0 and ready_o=1.
- Reset values (asynchronous, while rst_ni=0): s1_valid=0, s2_valid=0, valid_o=0, CNT=0, ERR=0, ERRCNT=0, S1 data=0. ready_o=1 immediately after reset.
- Reset mid-operation discards in-flight words; no partial result is emitted after reset release.

## Configuration
- THERMO_CHECK_EN defined:
  - The ERR logic and the ERRCNT counter are present.
  - errclr_i is functional.
- THERMO_CHECK_EN undefined:
  - ERR is tied to 0 and ERRCNT to 16'h0.
  - errclr_i is ignored, and the ERR/ERRCNT registers and comparison logic are removed.
  - CNT behaviour and timing are unchanged, including the trailing-ones result for illegal masks.

## Test plan
- Sweep, width=8, ready_i=1: stream TI=0x00,0x01,0x03,…,0xFF back-to-back. Expect CNT=0..8 in order, ERR=0, one result per cycle, and the first valid_o two edges after the first accept.
- Bubbles (THERMO_CHECK_EN): TI=0x0B then 0x80. Expect CNT=2,ERR=1, then CNT=0,ERR=1, and ERRCNT=2.
- Backpressure: ready_i=0 while sending 0x07, 0x0F, 0x1F. Expect ready_o=0 after two accepts, and CNT=3 held stable. Release ready_i and expect CNT=3,4,5 with no loss or duplication.
- Saturation/clear: preload ERRCNT near 16'hFFFF with bubble traffic and expect it to hold at 0xFFFF. Assert errclr_i in the same cycle as an error delivery and expect ERRCNT=0.
- Reset mid-stream: assert rst_ni=0 with both stages full. Expect valid_o=0, CNT=0 and ERRCNT=0 immediately. After release, expect no stale result and ready_o=1.
- Macro off: rerun the bubbles scenario and expect CNT=2 and 0, with ERR=0 and ERRCNT=0 throughout.

Source files
------------

// File: rtl/thermo_count.sv
// thermo_count: two-stage elastic thermometer-to-binary (trailing-ones) encoder.
// Define THERMO_CHECK_EN to build in bubble detection (ERR) and the ERRCNT counter.
module thermo_count #(
  parameter  int width = 8,
  localparam int cw    = $clog2(width+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [width-1:0] TI,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [cw-1:0]    CNT,
  output logic             ERR,
  output logic [15:0]      ERRCNT,
  input  logic             errclr_i
);

  logic [2:1]       vld_pipe;
  logic [width-1:0] s1_ti;
  logic [cw-1:0]    cnt_c;
  logic             s2_free, s2_ld, accept;

  assign s2_free = vld_pipe[2] & ready_i;
  assign s2_ld   = vld_pipe[1] & (~vld_pipe[2] | ready_i);
  assign ready_o = ~vld_pipe[1] | ~vld_pipe[2] | ready_i;
  assign accept  = valid_i & ready_o;
  assign valid_o = vld_pipe[2];

  // Index of the lowest zero bit, or width when the mask is all ones.
  always_comb begin
    cnt_c = cw'(width);
    for (int i = width-1; i >= 0; i--)
      if (!s1_ti[i]) cnt_c = cw'(i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      s1_ti    <= '0;
      CNT      <= '0;
    end else begin
      if (accept) begin
        vld_pipe[1] <= 1'b1;
        s1_ti       <= TI;
      end else if (s2_ld) begin
        vld_pipe[1] <= 1'b0;
      end
      if (s2_ld) begin
        vld_pipe[2] <= 1'b1;
        CNT         <= cnt_c;
      end else if (s2_free) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

`ifdef THERMO_CHECK_EN
  // A 0->1 step anywhere going upward means the mask is not 2^k-1;
  // kept independent of the count path.
  logic err_c;
  assign err_c = |(s1_ti[width-1:1] & ~s1_ti[width-2:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ERR    <= 1'b0;
      ERRCNT <= '0;
    end else begin
      if (s2_ld) ERR <= err_c;
      if (errclr_i)
        ERRCNT <= '0;
      else if (s2_free && ERR && ERRCNT != 16'hFFFF)
        ERRCNT <= ERRCNT + 16'd1;
    end
  end
`else
  logic unused_errclr;
  assign unused_errclr = errclr_i;
  assign ERR           = 1'b0;
  assign ERRCNT        = 16'h0;
`endif

endmodule

// File: tb/tb_thermo_count.sv
// Bench for thermo_count: constant vector table, hand sequences for backpressure,
// saturation and reset, and randomized traffic checked by a negedge scoreboard.
module tb_thermo_count;
  localparam int W = 8;
`ifdef THERMO_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk_i = 1'b0, rst_ni = 1'b0;
  logic         valid_i = 1'b0, ready_i = 1'b1, errclr_i = 1'b0;
  logic [W-1:0] TI = '0;
  logic         ready_o, valid_o, ERR;
  logic [3:0]   CNT;
  logic [15:0]  ERRCNT;

  thermo_count #(.width(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .TI(TI), .valid_o(valid_o), .ready_i(ready_i), .CNT(CNT), .ERR(ERR),
    .ERRCNT(ERRCNT), .errclr_i(errclr_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count ones from bit 0 upward; legal iff mask equals 2^k-1.
  function automatic void ref_m(input logic [W-1:0] t, output int k, output bit e);
    k = 0;
    while (k < W && t[k]) k++;
    e = (32'(t) != ((32'd1 << k) - 32'd1));
  endfunction

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  // Scoreboard: values seen at negedge are the values present at the next posedge.
  logic [W-1:0] q[$];
  logic [15:0]  em = '0;
  bit           hold = 0, herr;
  logic [3:0]   hcnt;

  always @(negedge clk_i) begin
    int  k;
    bit  e;
    bit  del_err;
    logic [W-1:0] t;
    if (!rst_ni) begin
      q.delete(); em = '0; hold = 0;
    end else begin
      del_err = 0;
      chk("errcnt", 32'(ERRCNT), 32'(em));
      chk("ready_o", 32'(ready_o), 32'(q.size() < 2 || ready_i));
      if (hold) begin
        chk("hold_valid", 32'(valid_o), 1);
        chk("hold_cnt", 32'(CNT), 32'(hcnt));
        chk("hold_err", 32'(ERR), 32'(herr));
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else begin
          t = q.pop_front();
          ref_m(t, k, e);
          del_err = e & CHK;
          chk("sb_cnt", 32'(CNT), 32'(k));
          chk("sb_err", 32'(ERR), 32'(del_err));
        end
      end
      hold = valid_o && !ready_i; hcnt = CNT; herr = ERR;
      if (CHK && errclr_i) em = '0;
      else if (del_err && em != 16'hFFFF) em = em + 16'd1;
      if (valid_i && ready_o) q.push_back(TI);
    end
  end

  typedef struct { logic [W-1:0] ti; int cnt; bit err; } vec_t;
  vec_t tab[$];

  task automatic drain(input string name);
    int n = 0;
    valid_i = 0; ready_i = 1;
    while ((q.size() != 0 || valid_o) && n < 20) begin cyc(); n++; end
    chk(name, 32'(q.size() == 0 && !valid_o), 1);
  endtask

  initial begin
    for (int k = 0; k <= W; k++) tab.push_back('{W'((1 << k) - 1), k, 1'b0});
    tab.push_back('{8'h0B, 2, 1'b1});
    tab.push_back('{8'h80, 0, 1'b1});

    // Reset state
    #2;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_cnt", 32'(CNT), 0);
    chk("rst_err", 32'(ERR), 0);
    chk("rst_errcnt", 32'(ERRCNT), 0);
    chk("rst_ready", 32'(ready_o), 1);
    cyc(); cyc();
    rst_ni = 1;
    cyc();

    // Sweep + bubbles, back-to-back, two-edge latency
    for (int e = 0; e <= tab.size(); e++) begin
      if (e < tab.size()) begin valid_i = 1; TI = tab[e].ti; end
      else valid_i = 0;
      cyc();
      if (e == 0) chk("lat_first", 32'(valid_o), 0);
      else begin
        chk("tab_valid", 32'(valid_o), 1);
        chk("tab_cnt", 32'(CNT), 32'(tab[e-1].cnt));
        chk("tab_err", 32'(ERR), 32'(tab[e-1].err & CHK));
      end
    end
    cyc();
    chk("tab_errcnt", 32'(ERRCNT), CHK ? 2 : 0);
    chk("tab_empty", 32'(valid_o), 0);

    // Backpressure
    ready_i = 0; valid_i = 1; TI = 8'h07;
    cyc();
    TI = 8'h0F;
    cyc();
    TI = 8'h1F; #1;
    chk("bp_full_ready", 32'(ready_o), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_cnt", 32'(CNT), 3);
      chk("bp_hold_ready", 32'(ready_o), 0);
    end
    ready_i = 1; #1;
    chk("bp_release_ready", 32'(ready_o), 1);
    cyc(); valid_i = 0;
    chk("bp_cnt4", 32'(CNT), 4);
    cyc();
    chk("bp_cnt5", 32'(CNT), 5);
    cyc();
    chk("bp_empty", 32'(valid_o), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      valid_i  = ($urandom_range(0, 3) != 0);
      ready_i  = ($urandom_range(0, 2) != 0);
      errclr_i = ($urandom_range(0, 19) == 0);
      TI = $urandom_range(0, 1) ? W'((1 << $urandom_range(0, W)) - 1) : W'($urandom);
      cyc();
    end
    errclr_i = 0;
    drain("rand_drain");

    // Saturation then clear coinciding with an error delivery
    valid_i = 1; TI = 8'h80; ready_i = 1;
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat_errcnt", 32'(ERRCNT), CHK ? 32'hFFFF : 0);
    chk("clr_pre_err", 32'(valid_o && ERR), 32'(CHK));
    valid_i = 0; errclr_i = 1;
    cyc();
    errclr_i = 0;
    chk("clr_wins", 32'(ERRCNT), 0);
    drain("sat_drain");

    // Reset with both stages full
    ready_i = 0; valid_i = 1; TI = 8'h0B;
    cyc(); cyc(); cyc();
    valid_i = 0;
    rst_ni = 0; #1;
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_cnt", 32'(CNT), 0);
    chk("mrst_errcnt", 32'(ERRCNT), 0);
    @(negedge clk_i);
    cyc();
    rst_ni = 1; ready_i = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mrst_no_stale", 32'(valid_o), 0);
      chk("mrst_ready", 32'(ready_o), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
